// File: rtl/stream_fill_arbiter.sv
// Two-channel fill arbiter: grants a single byte source to whichever FIFO has
// dropped below its low watermark, in round-robin order, in bursts of up to BURST bytes.
module stream_fill_arbiter #(
    parameter int BURST     = 512,
    parameter int LOW_WM    = 1024,
    parameter int HIGH_WM   = 1536,
    parameter int DRAIN_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en0,
    input  logic        en1,
    input  logic [10:0] usedw0,
    input  logic [10:0] usedw1,
    input  logic        full0,
    input  logic        full1,
    output logic        src_read_req,
    input  logic [7:0]  src_data,
    input  logic        src_data_valid,
    input  logic        src_end,
    output logic [7:0]  wr_data,
    output logic        wr_req0,
    output logic        wr_req1,
    output logic        grant0,
    output logic        grant1,
    output logic        stream_over,
    output logic        drop_err,
    output logic        ovf_err
);

    localparam logic [9:0]  BURST_C    = 10'(BURST);
    localparam logic [9:0]  BURST_M1   = 10'(BURST - 1);
    localparam logic [10:0] LOW_WM_C   = 11'(LOW_WM);
    localparam logic [10:0] HIGH_WM_M1 = 11'(HIGH_WM - 1);
    localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic [9:0] r_cnt;
    logic [3:0] r_drain_cnt;
    logic       r_src_read_req;
    logic       r_grant0;
    logic       r_grant1;
    logic       r_stream_over;
    logic       r_drop_err;
    logic       r_ovf_err;

    logic        w_req0;
    logic        w_req1;
    logic        w_busy;
    logic [10:0] w_owner_usedw;
    logic        w_owner_full;
    logic        w_owner_en;
    logic        w_wr_req0;
    logic        w_wr_req1;
    logic        w_accept;
    logic        w_cnt_done;
    logic        w_grant_stop;
    logic        w_drop;
    logic        w_ovf;

    assign w_req0 = en0 && !full0 && (usedw0 < LOW_WM_C);
    assign w_req1 = en1 && !full1 && (usedw1 < LOW_WM_C);

    assign w_busy        = (r_state == S_GRANT) || (r_state == S_DRAIN);
    assign w_owner_usedw = r_owner ? usedw1 : usedw0;
    assign w_owner_full  = r_owner ? full1 : full0;
    assign w_owner_en    = r_owner ? en1 : en0;

    // Write strobes are combinational so a byte lands in the FIFO the cycle it arrives.
    assign w_wr_req0 = rst_n && src_data_valid && w_busy && !r_owner && !full0;
    assign w_wr_req1 = rst_n && src_data_valid && w_busy &&  r_owner && !full1;
    assign w_accept  = (r_state == S_GRANT) && (w_wr_req0 || w_wr_req1);

    // Burst is complete on the cycle the final byte is accepted, so no extra byte is requested.
    assign w_cnt_done   = (r_cnt == BURST_C) || (w_accept && (r_cnt == BURST_M1));
    assign w_grant_stop = w_cnt_done || (w_owner_usedw > HIGH_WM_M1) || w_owner_full || !w_owner_en;

    assign w_drop = src_data_valid && !w_busy;
    assign w_ovf  = src_data_valid && w_busy && w_owner_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_last         <= 1'b1;
            r_cnt          <= 10'd0;
            r_drain_cnt    <= 4'd0;
            r_src_read_req <= 1'b0;
            r_grant0       <= 1'b0;
            r_grant1       <= 1'b0;
            r_stream_over  <= 1'b0;
            r_drop_err     <= 1'b0;
            r_ovf_err      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end

            if (src_end) begin
                r_state        <= S_END;
                r_src_read_req <= 1'b0;
                r_grant0       <= 1'b0;
                r_grant1       <= 1'b0;
                r_stream_over  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // r_last==1 means channel 1 was served last, so channel 0 wins a tie.
                        if (w_req0 && (!w_req1 || r_last)) begin
                            r_state        <= S_GRANT;
                            r_owner        <= 1'b0;
                            r_cnt          <= 10'd0;
                            r_src_read_req <= 1'b1;
                            r_grant0       <= 1'b1;
                            r_grant1       <= 1'b0;
                        end else if (w_req1) begin
                            r_state        <= S_GRANT;
                            r_owner        <= 1'b1;
                            r_cnt          <= 10'd0;
                            r_src_read_req <= 1'b1;
                            r_grant0       <= 1'b0;
                            r_grant1       <= 1'b1;
                        end
                    end
                    S_GRANT: begin
                        if (w_accept && (r_cnt != BURST_C)) begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                        if (w_grant_stop) begin
                            r_state        <= S_DRAIN;
                            r_src_read_req <= 1'b0;
                            r_drain_cnt    <= DRAIN_INIT;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == 4'd0) begin
                            r_state  <= S_IDLE;
                            r_last   <= r_owner;
                            r_grant0 <= 1'b0;
                            r_grant1 <= 1'b0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_src_read_req <= 1'b0;
                        r_grant0       <= 1'b0;
                        r_grant1       <= 1'b0;
                        r_stream_over  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign src_read_req = r_src_read_req;
    assign grant0       = r_grant0;
    assign grant1       = r_grant1;
    assign stream_over  = r_stream_over;
    assign drop_err     = r_drop_err;
    assign ovf_err      = r_ovf_err;
    assign wr_data      = src_data;
    assign wr_req0      = w_wr_req0;
    assign wr_req1      = w_wr_req1;

endmodule

// File: tb/tb_stream_fill_arbiter.sv
// Directed bench for stream_fill_arbiter: reset, round-robin bursts, watermark, overflow,
// drop, end-of-stream and mid-grant reset scenarios.
module tb_stream_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [10:0] usedw0 = 11'd0;
    logic [10:0] usedw1 = 11'd0;
    logic        full0 = 1'b0;
    logic        full1 = 1'b0;
    logic        src_read_req;
    logic [7:0]  src_data = 8'd0;
    logic        src_data_valid = 1'b0;
    logic        src_end = 1'b0;
    logic [7:0]  wr_data;
    logic        wr_req0;
    logic        wr_req1;
    logic        grant0;
    logic        grant1;
    logic        stream_over;
    logic        drop_err;
    logic        ovf_err;

    int n_vec = 0;
    int n_err = 0;

    stream_fill_arbiter #(
        .BURST(512), .LOW_WM(1024), .HIGH_WM(1536), .DRAIN_LAT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en0(en0), .en1(en1),
        .usedw0(usedw0), .usedw1(usedw1), .full0(full0), .full1(full1),
        .src_read_req(src_read_req), .src_data(src_data),
        .src_data_valid(src_data_valid), .src_end(src_end),
        .wr_data(wr_data), .wr_req0(wr_req0), .wr_req1(wr_req1),
        .grant0(grant0), .grant1(grant1), .stream_over(stream_over),
        .drop_err(drop_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Step past the next rising edge; inputs are driven here, outputs sampled #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_data_valid = 1'b0;
        src_end = 1'b0;
        full0 = 1'b0;
        full1 = 1'b0;
        usedw0 = 11'd0;
        usedw1 = 11'd0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input bit ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if ((ch == 1'b0 && grant0) || (ch == 1'b1 && grant1)) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_grant%0d: got no grant in 20 cycles, required grant", ch);
        end
    endtask

    task automatic test_reset();
        en0 = 1'b0; en1 = 1'b0;
        do_reset();
        #1;
        n_vec++;
        if ({src_read_req, grant0, grant1, stream_over, drop_err, ovf_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {src_read_req, grant0, grant1, stream_over, drop_err, ovf_err});
        end
        n_vec++;
        if ({wr_req0, wr_req1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_wr_req: got %b required 00", {wr_req0, wr_req1});
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        int c0 = 0;
        int c1 = 0;
        int d0 = 0;
        bit saw1 = 1'b0;
        bit done1 = 1'b0;
        bit order_bad = 1'b0;
        en0 = 1'b1; en1 = 1'b1;
        do_reset();
        for (int i = 0; i < 1200 && !done1; i++) begin
            cyc();
            src_data_valid = src_read_req;
            src_data = i[7:0];
            #1;
            if (grant1 && c0 == 0) order_bad = 1'b1;
            if (!saw1) begin
                if (wr_req0) c0++;
                if (grant0 && !src_read_req) d0++;
            end
            if (grant1) saw1 = 1'b1;
            if (saw1 && !done1 && wr_req1) c1++;
            if (saw1 && !grant1) done1 = 1'b1;
        end
        src_data_valid = 1'b0;
        n_vec++;
        if (order_bad) begin
            n_err++;
            $display("FAIL rr_order: got channel 1 first, required channel 0 first");
        end
        n_vec++;
        if (c0 != 512) begin
            n_err++;
            $display("FAIL rr_burst0: got %0d wr_req0 pulses, required 512", c0);
        end
        n_vec++;
        if (d0 != 4) begin
            n_err++;
            $display("FAIL rr_drain0: got %0d drain cycles, required 4", d0);
        end
        n_vec++;
        if (c1 != 512) begin
            n_err++;
            $display("FAIL rr_burst1: got %0d wr_req1 pulses, required 512", c1);
        end
        $display("test_round_robin done: c0=%0d drain=%0d c1=%0d", c0, d0, c1);
    endtask

    task automatic test_high_wm();
        bit ok;
        int cnt = 0;
        en0 = 1'b1; en1 = 1'b0;
        do_reset();
        wait_grant(1'b0, ok);
        for (int i = 0; i < 200 && cnt < 100; i++) begin
            if (i > 0) cyc();
            src_data_valid = src_read_req;
            #1;
            if (wr_req0) cnt++;
        end
        cyc();
        src_data_valid = 1'b0;
        usedw0 = 11'd1536;
        cyc();
        n_vec++;
        if ({src_read_req, grant0} !== 2'b01) begin
            n_err++;
            $display("FAIL hwm_drop_req: got req/grant0 %b required 01", {src_read_req, grant0});
        end
        for (int k = 0; k < 2; k++) begin
            src_data_valid = 1'b1;
            #1;
            if (wr_req0) cnt++;
            n_vec++;
            if (wr_req0 !== 1'b1) begin
                n_err++;
                $display("FAIL hwm_drain_write%0d: got wr_req0 %b required 1", k, wr_req0);
            end
            cyc();
        end
        src_data_valid = 1'b0;
        n_vec++;
        if (cnt != 102) begin
            n_err++;
            $display("FAIL hwm_burst_len: got %0d bytes, required 102", cnt);
        end
        for (int k = 0; k < 6; k++) cyc();
        n_vec++;
        if ({src_read_req, grant0} !== 2'b00) begin
            n_err++;
            $display("FAIL hwm_no_regrant: got req/grant0 %b required 00", {src_read_req, grant0});
        end
        $display("test_high_wm done: bytes=%0d", cnt);
    endtask

    task automatic test_full_ovf();
        bit ok;
        en0 = 1'b1; en1 = 1'b0;
        do_reset();
        wait_grant(1'b0, ok);
        cyc();
        src_data_valid = 1'b1;
        full0 = 1'b1;
        #1;
        n_vec++;
        if (wr_req0 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_wr_req: got %b required 0", wr_req0);
        end
        cyc();
        src_data_valid = 1'b0;
        #1;
        n_vec++;
        if ({ovf_err, src_read_req, grant0, drop_err} !== 4'b1010) begin
            n_err++;
            $display("FAIL ovf_state: got ovf/req/grant0/drop %b required 1010",
                     {ovf_err, src_read_req, grant0, drop_err});
        end
        $display("test_full_ovf done");
    endtask

    task automatic test_drop();
        en0 = 1'b0; en1 = 1'b0;
        do_reset();
        cyc();
        src_data_valid = 1'b1;
        src_data = 8'h5A;
        #1;
        n_vec++;
        if ({wr_req0, wr_req1} !== 2'b00) begin
            n_err++;
            $display("FAIL drop_wr_req: got %b required 00", {wr_req0, wr_req1});
        end
        n_vec++;
        if (wr_data !== 8'h5A) begin
            n_err++;
            $display("FAIL wr_data_pass: got %h required 5a", wr_data);
        end
        cyc();
        src_data_valid = 1'b0;
        #1;
        n_vec++;
        if (drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_set: got %b required 1", drop_err);
        end
        for (int k = 0; k < 5; k++) cyc();
        n_vec++;
        if (drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_sticky: got %b required 1", drop_err);
        end
        do_reset();
        #1;
        n_vec++;
        if (drop_err !== 1'b0) begin
            n_err++;
            $display("FAIL drop_clear: got %b required 0", drop_err);
        end
        $display("test_drop done");
    endtask

    task automatic test_end();
        bit ok;
        en0 = 1'b1; en1 = 1'b0;
        do_reset();
        wait_grant(1'b0, ok);
        cyc();
        src_data_valid = 1'b1;
        src_end = 1'b1;
        #1;
        n_vec++;
        if (wr_req0 !== 1'b1) begin
            n_err++;
            $display("FAIL end_byte_routed: got %b required 1", wr_req0);
        end
        cyc();
        src_data_valid = 1'b0;
        src_end = 1'b0;
        #1;
        n_vec++;
        if ({src_read_req, grant0, grant1, stream_over} !== 4'b0001) begin
            n_err++;
            $display("FAIL end_state: got req/g0/g1/over %b required 0001",
                     {src_read_req, grant0, grant1, stream_over});
        end
        en1 = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        n_vec++;
        if ({src_read_req, grant0, grant1, stream_over} !== 4'b0001) begin
            n_err++;
            $display("FAIL end_held: got req/g0/g1/over %b required 0001",
                     {src_read_req, grant0, grant1, stream_over});
        end
        $display("test_end done");
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        en0 = 1'b0; en1 = 1'b1;
        do_reset();
        wait_grant(1'b1, ok);
        cyc();
        rst_n = 1'b0;
        en0 = 1'b1;
        src_data_valid = 1'b1;
        #1;
        n_vec++;
        if ({wr_req0, wr_req1} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_wr_req: got %b required 00", {wr_req0, wr_req1});
        end
        cyc();
        rst_n = 1'b1;
        src_data_valid = 1'b0;
        #1;
        n_vec++;
        if ({src_read_req, grant0, grant1, stream_over, drop_err, ovf_err} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %b required 000000",
                     {src_read_req, grant0, grant1, stream_over, drop_err, ovf_err});
        end
        cyc();
        #1;
        n_vec++;
        if ({grant0, grant1, src_read_req} !== 3'b101) begin
            n_err++;
            $display("FAIL rst_tie_ch0: got g0/g1/req %b required 101", {grant0, grant1, src_read_req});
        end
        $display("test_reset_mid_grant done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_high_wm();
        test_full_ovf();
        test_drop();
        test_end();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
